// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states and the
// constants used to size the transmitter watchdog.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT
  } arb_state_t;

  // uart_tx samples 16 ticks per bit; a frame is start + 8 data + stop.
  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned FRAME_BITS     = 10;
  localparam int unsigned TIMEOUT_MARGIN = 2;

  // Watchdog budget for one frame at a given baud-tick divisor, with margin.
  function automatic int unsigned timeout_for_divisor(input int unsigned baud_div);
    return OVERSAMPLE * FRAME_BITS * baud_div * TIMEOUT_MARGIN;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin pick: first set request at or above rr_ptr, wrapping to 0.
// Built as rotate -> priority encode -> unrotate so rr_ptr may be any
// value below N_REQ, including non-power-of-two requester counts.
module uart_tx_arb_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] offset;
  int unsigned      rot_idx;
  int unsigned      sum;

  // Rotate the request vector so rr_ptr lands at bit 0.
  always_comb begin
    rot     = '0;
    rot_idx = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rot_idx = i + int'(rr_ptr);
      if (rot_idx >= N_REQ) rot_idx = rot_idx - N_REQ;
      rot[IDX_W'(i)] = req[IDX_W'(rot_idx)];
    end
  end

  // Lowest set bit of the rotated vector is the winner's distance from rr_ptr.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[IDX_W'(i)] && !found) begin
        found  = 1'b1;
        offset = IDX_W'(i);
      end
    end
  end

  // Undo the rotation with an explicit modulo-N_REQ wrap.
  always_comb begin
    sum = int'(offset) + int'(rr_ptr);
    if (sum >= N_REQ) sum = sum - N_REQ;
    winner = IDX_W'(sum);
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers.
// Captures a byte, pulses tx_start, waits for tx_done_tick (or a watchdog
// expiry), reports per-requester done/timeout, then re-arbitrates.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter int unsigned CNT_W       = 21
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_timeout,
  output logic               tx_start,
  output logic [7:0]         tx_din,
  input  logic               tx_done_tick,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             wd_expire;
  logic [IDX_W-1:0] next_ptr;

  logic [N_REQ-1:0] ack_d, done_d, timeout_d;
  logic             start_d, busy_d;
  logic [7:0]       din_d;
  logic [IDX_W-1:0] grant_d;

  uart_tx_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .found  (pick_found)
  );

  // Watchdog terminal count and the pointer value after the current grant.
  always_comb begin
    wd_expire = (TIMEOUT_CYC != 0) && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    next_ptr  = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a done tick takes priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_found) state_d = ARB_START;
      ARB_START: state_d = ARB_WAIT;
      ARB_WAIT:  if (tx_done_tick || wd_expire) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and watchdog.
  always_comb begin
    ack_d     = '0;
    done_d    = '0;
    timeout_d = '0;
    start_d   = 1'b0;
    busy_d    = busy;
    din_d     = tx_din;
    grant_d   = grant_id;
    rr_ptr_d  = rr_ptr;
    wd_cnt_d  = wd_cnt;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) din_d = req_data[8*i +: 8];
          end
          grant_d         = pick_idx;
          ack_d[pick_idx] = 1'b1;
          busy_d          = 1'b1;
        end
      end
      ARB_START: begin
        start_d  = 1'b1;
        wd_cnt_d = '0;
      end
      ARB_WAIT: begin
        if (tx_done_tick) begin
          done_d[grant_id] = 1'b1;
          busy_d           = 1'b0;
          rr_ptr_d         = next_ptr;
        end else if (wd_expire) begin
          timeout_d[grant_id] = 1'b1;
          busy_d              = 1'b0;
          rr_ptr_d            = next_ptr;
        end else if (wd_cnt != '1) begin
          wd_cnt_d = wd_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output, pointer and watchdog registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ack     <= '0;
      req_done    <= '0;
      req_timeout <= '0;
      tx_start    <= 1'b0;
      tx_din      <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
    end else begin
      req_ack     <= ack_d;
      req_done    <= done_d;
      req_timeout <= timeout_d;
      tx_start    <= start_d;
      tx_din      <= din_d;
      busy        <= busy_d;
      grant_id    <= grant_d;
      rr_ptr      <= rr_ptr_d;
      wd_cnt      <= wd_cnt_d;
    end
  end

endmodule
